// File: rtl/musa_control_unit_pkg.sv
// Shared MUSA control-unit definitions: opcode/funct encodings, FSM state type
// and the registered control-strobe bundle.
package musa_control_unit_pkg;

  localparam logic [5:0] R_TYPE_OPCODE = 6'h00;
  localparam logic [5:0] JPC_OPCODE    = 6'h02;
  localparam logic [5:0] JR_OPCODE     = 6'h03;
  localparam logic [5:0] BRFL_OPCODE   = 6'h04;
  localparam logic [5:0] CALL_OPCODE   = 6'h05;
  localparam logic [5:0] RET_OPCODE    = 6'h06;
  localparam logic [5:0] CMP_OPCODE    = 6'h07;
  localparam logic [5:0] ADDI_OPCODE   = 6'h08;
  localparam logic [5:0] SUBI_OPCODE   = 6'h09;
  localparam logic [5:0] ANDI_OPCODE   = 6'h0C;
  localparam logic [5:0] ORI_OPCODE    = 6'h0D;
  localparam logic [5:0] LW_OPCODE     = 6'h23;
  localparam logic [5:0] SW_OPCODE     = 6'h2B;
  localparam logic [5:0] NOP_OPCODE    = 6'h3A;
  localparam logic [5:0] HALT_OPCODE   = 6'h3B;

  localparam logic [5:0] MULT_FUNCT = 6'h18;
  localparam logic [5:0] DIV_FUNCT  = 6'h1A;
  localparam logic [5:0] ADD_FUNCT  = 6'h20;
  localparam logic [5:0] SUB_FUNCT  = 6'h22;
  localparam logic [5:0] AND_FUNCT  = 6'h24;
  localparam logic [5:0] OR_FUNCT   = 6'h25;
  localparam logic [5:0] NOT_FUNCT  = 6'h27;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    RUN         = 2'd1,
    MULDIV_WAIT = 2'd2,
    HALTED      = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    logic rd1;
    logic rd2;
    logic a_wr;
    logic b_wr;
    logic imm;
    logic mem_rd;
    logic mem_wr;
    logic wb_sel;
    logic branch;
    logic branch_use_r;
    logic jump;
    logic jump_use_r;
    logic illegal;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_NONE = '{default: 1'b0};

endpackage

// File: rtl/musa_opcode_decoder.sv
// Combinational opcode/funct decoder producing the strobe bundle and the
// sequencing hints (multi-cycle, halt, illegal) used by the control FSM.
module musa_opcode_decoder
  import musa_control_unit_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output ctrl_bundle_t ctrl,
  output logic         is_muldiv,
  output logic         is_halt,
  output logic         illegal
);

  // Strobe lookup; the illegal flag is reported separately, not via ctrl.
  always_comb begin
    ctrl      = CTRL_NONE;
    is_muldiv = 1'b0;
    is_halt   = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      SW_OPCODE: begin
        ctrl.rd1 = 1'b1; ctrl.rd2 = 1'b1; ctrl.imm = 1'b1; ctrl.mem_wr = 1'b1;
      end
      LW_OPCODE: begin
        ctrl.rd1 = 1'b1; ctrl.a_wr = 1'b1; ctrl.imm = 1'b1;
        ctrl.mem_rd = 1'b1; ctrl.wb_sel = 1'b1;
      end
      ADDI_OPCODE, SUBI_OPCODE, ANDI_OPCODE, ORI_OPCODE: begin
        ctrl.rd1 = 1'b1; ctrl.a_wr = 1'b1; ctrl.imm = 1'b1;
      end
      JPC_OPCODE: ctrl.jump = 1'b1;
      BRFL_OPCODE: begin
        ctrl.rd1 = 1'b1; ctrl.imm = 1'b1; ctrl.branch = 1'b1; ctrl.branch_use_r = 1'b1;
      end
      JR_OPCODE, CALL_OPCODE: begin
        ctrl.a_wr = 1'b1; ctrl.jump = 1'b1;
      end
      RET_OPCODE: begin
        ctrl.rd1 = 1'b1; ctrl.jump = 1'b1; ctrl.jump_use_r = 1'b1;
      end
      CMP_OPCODE: begin
        ctrl.rd1 = 1'b1; ctrl.rd2 = 1'b1;
      end
      R_TYPE_OPCODE: begin
        case (funct)
          ADD_FUNCT, SUB_FUNCT, AND_FUNCT, OR_FUNCT, NOT_FUNCT: begin
            ctrl.rd1 = 1'b1; ctrl.rd2 = 1'b1; ctrl.a_wr = 1'b1;
          end
          MULT_FUNCT, DIV_FUNCT: begin
            ctrl.rd1 = 1'b1; ctrl.rd2 = 1'b1; ctrl.a_wr = 1'b1; ctrl.b_wr = 1'b1;
            is_muldiv = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      NOP_OPCODE:  ctrl = CTRL_NONE;
      HALT_OPCODE: is_halt = 1'b1;
      default:     illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/musa_control_unit.sv
// MUSA control unit: fetch gating FSM, MUL/DIV stall counter and the
// registered per-instruction control strobes.
module musa_control_unit
  import musa_control_unit_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic                  clk_musa,
  input  logic                  rst_n,
  input  logic                  boot_mode,
  input  logic                  instr_valid,
  input  logic [DATA_WIDTH-1:0] instruction,
  output logic                  instr_rd_en,
  output logic                  reg_rd_en1_out,
  output logic                  reg_rd_en2_out,
  output logic                  reg_a_wr_en_out,
  output logic                  reg_b_wr_en_out,
  output logic                  imm_inst_out,
  output logic                  mem_data_rd_en_out,
  output logic                  mem_data_wr_en_out,
  output logic                  write_back_mux_sel_out,
  output logic                  branch_inst_out,
  output logic                  branch_use_r_out,
  output logic                  jump_inst_out,
  output logic                  jump_use_r_out,
  output logic                  stall_out,
  output logic                  halted,
  output logic                  illegal_instr
);

  localparam logic [3:0] CNT_LOAD = 4'(MULDIV_CYCLES - 1);

  ctrl_state_t  state_r, state_n;
  logic [3:0]   cnt_r, cnt_n;
  ctrl_bundle_t ctrl_r, ctrl_n, dec_ctrl_s;
  logic         dec_muldiv_s, dec_halt_s, dec_illegal_s;
  logic         rd_en_r, stall_r, halted_r;
  logic         unused_instr_bits_s;

  assign unused_instr_bits_s = ^instruction[DATA_WIDTH-7:6];

  musa_opcode_decoder u_decoder (
    .opcode    (instruction[DATA_WIDTH-1 -: 6]),
    .funct     (instruction[5:0]),
    .ctrl      (dec_ctrl_s),
    .is_muldiv (dec_muldiv_s),
    .is_halt   (dec_halt_s),
    .illegal   (dec_illegal_s)
  );

  // Next state, stall counter and strobes to register this edge.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    ctrl_n  = CTRL_NONE;
    case (state_r)
      IDLE: begin
        if (!boot_mode) state_n = RUN;
        else            state_n = IDLE;
      end
      RUN: begin
        if (boot_mode) begin
          state_n = IDLE;
        end else if (instr_valid) begin
          ctrl_n         = dec_ctrl_s;
          ctrl_n.illegal = dec_illegal_s;
          if (dec_muldiv_s) begin
            state_n = MULDIV_WAIT;
            cnt_n   = CNT_LOAD;
          end else if (dec_halt_s) begin
            state_n = HALTED;
          end else begin
            state_n = RUN;
          end
        end else begin
          state_n = RUN;
        end
      end
      MULDIV_WAIT: begin
        if (cnt_r == 4'd0) state_n = RUN;
        else               cnt_n   = cnt_r - 4'd1;
      end
      HALTED:  state_n = HALTED;
      default: state_n = IDLE;
    endcase
  end

  // State, counter and output registers; status flags follow the next state.
  always_ff @(posedge clk_musa or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      ctrl_r   <= CTRL_NONE;
      rd_en_r  <= 1'b0;
      stall_r  <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_n;
      cnt_r    <= cnt_n;
      ctrl_r   <= ctrl_n;
      rd_en_r  <= (state_n == RUN);
      stall_r  <= (state_n == MULDIV_WAIT);
      halted_r <= (state_n == HALTED);
    end
  end

  assign instr_rd_en            = rd_en_r;
  assign stall_out              = stall_r;
  assign halted                 = halted_r;
  assign reg_rd_en1_out         = ctrl_r.rd1;
  assign reg_rd_en2_out         = ctrl_r.rd2;
  assign reg_a_wr_en_out        = ctrl_r.a_wr;
  assign reg_b_wr_en_out        = ctrl_r.b_wr;
  assign imm_inst_out           = ctrl_r.imm;
  assign mem_data_rd_en_out     = ctrl_r.mem_rd;
  assign mem_data_wr_en_out     = ctrl_r.mem_wr;
  assign write_back_mux_sel_out = ctrl_r.wb_sel;
  assign branch_inst_out        = ctrl_r.branch;
  assign branch_use_r_out       = ctrl_r.branch_use_r;
  assign jump_inst_out          = ctrl_r.jump;
  assign jump_use_r_out         = ctrl_r.jump_use_r;
  assign illegal_instr          = ctrl_r.illegal;

endmodule

// File: doc/musa_control_unit.md
Name: musa_control_unit

Overview:
- Registered instruction-decode and sequencing unit of the MUSA core.
- Consumes fetched 32-bit instructions and drives the per-instruction control strobes that the verification interface monitors: register read/write enables, immediate select, memory enables, write-back mux select, branch and jump controls.
- Owns fetch gating, multi-cycle MUL/DIV stall, boot hold and HALT.
- Sits between instruction memory and the datapath.

Parameters:
- DATA_WIDTH, 32, instruction width. Opcode is [31:26]; funct is [5:0].
- MULDIV_CYCLES, 4, stall cycles for MULT/DIV. Legal range 1..15.

Ports:
- clk_musa  input  1  core clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- boot_mode  input  1  1 = memory being loaded; core held idle
- instr_valid  input  1  instruction bus holds a fetched word this cycle
- instruction  input  DATA_WIDTH  fetched instruction
- instr_rd_en  output  1  fetch request to instruction memory
- reg_rd_en1_out  output  1  register file read port 1 enable
- reg_rd_en2_out  output  1  register file read port 2 enable
- reg_a_wr_en_out  output  1  write port A enable
- reg_b_wr_en_out  output  1  write port B enable (hi/remainder)
- imm_inst_out  output  1  ALU operand B = immediate
- mem_data_rd_en_out  output  1  data memory read
- mem_data_wr_en_out  output  1  data memory write
- write_back_mux_sel_out  output  1  1 = write back memory data, 0 = ALU result
- branch_inst_out  output  1  conditional branch
- branch_use_r_out  output  1  branch target from register
- jump_inst_out  output  1  jump
- jump_use_r_out  output  1  jump target from register
- stall_out  output  1  pipeline stall
- halted  output  1  core stopped by HALT
- illegal_instr  output  1  one-cycle pulse on an undecodable opcode or funct

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - state = IDLE, counter = 0.
  - Every output = 0 immediately, without waiting for a clock edge.
  - Reset asserted in any state, including mid-MULDIV or HALTED, returns the unit to IDLE.
- FSM states: IDLE, RUN, MULDIV_WAIT, HALTED.
  - IDLE: instr_rd_en = 0. Moves to RUN on the first edge with boot_mode = 0.
  - RUN: instr_rd_en = 1. If boot_mode = 1 is sampled, return to IDLE and do not decode that cycle's instruction.
  - MULDIV_WAIT: instr_rd_en = 0 and stall_out = 1.
  - HALTED: instr_rd_en = 0 and halted = 1. Left only through reset.
- Decode timing:
  - In RUN, instr_valid = 1 at edge T registers the decoded strobes.
  - Strobes are visible for exactly the cycle after T (latency 1), then return to 0 unless a new instruction is decoded.
  - instr_valid is ignored in IDLE, MULDIV_WAIT and HALTED.
- Strobe set per instruction (all strobes not listed = 0):
  - SW: rd1, rd2, imm, mem_wr
  - LW: rd1, a_wr, imm, mem_rd, wb_sel
  - ADDI, SUBI, ANDI, ORI: rd1, a_wr, imm
  - JPC: jump
  - BRFL: rd1, imm, branch, branch_use_r
  - JR, CALL: a_wr, jump
  - RET: rd1, jump, jump_use_r
  - R_TYPE with ADD, SUB, AND, OR or NOT funct: rd1, rd2, a_wr
  - R_TYPE with MULT or DIV funct: rd1, rd2, a_wr, b_wr
  - CMP: rd1, rd2
  - NOP: none
  - HALT: none
- MULT/DIV:
  - Decoded at edge T: strobes are active in cycle T+1.
  - State = MULDIV_WAIT with counter loaded to MULDIV_CYCLES-1.
  - stall_out = 1 and instr_rd_en = 0 from T+1 through T+MULDIV_CYCLES.
  - Counter decrements each cycle; on the edge where counter = 0, return to RUN.
  - Back-to-back MULT re-enters MULDIV_WAIT normally.
- HALT:
  - Decoded at T: halted = 1 from T+1, and stays 1.
  - All strobes stay 0 in HALTED.
- Illegal opcode, or illegal funct under R_TYPE:
  - All strobes 0 and illegal_instr = 1 for one cycle.
  - State remains RUN.
- Simultaneous events: boot_mode = 1 together with instr_valid = 1 in RUN → boot wins; nothing is decoded.
- Invariant: at most one of mem_rd or mem_wr, and at most one of branch or jump, is asserted in any cycle.

Decomposition:
- Shared package (defines.sv / opcodes.sv):
  - opcode and funct constants (already present)
  - ctrl_state_t enum (IDLE, RUN, MULDIV_WAIT, HALTED)
  - ctrl_bundle_t packed struct holding the 13 strobes, plus a CTRL_NONE constant
- Sub-module musa_opcode_decoder:
  - Purely combinational; instruction → ctrl_bundle_t + is_muldiv, is_halt, illegal.
  - Top level holds the FSM, the counter and the output register.

Test Plan:
- Reset, then boot_mode 1→0 at cycle 3 → all outputs 0 during reset; instr_rd_en rises at cycle 4.
- LW at edge T (opcode = LW_OPCODE, instruction 0x8C22_0004 form) → cycle T+1 has rd1, a_wr, imm, mem_rd, wb_sel = 1 and all others 0; T+2 all 0.
- R_TYPE with funct MULT, MULDIV_CYCLES = 4, decoded at edge T:
  - T+1: rd1, rd2, a_wr, b_wr = 1.
  - T+1..T+4: stall_out = 1, instr_rd_en = 0.
  - T+5: instr_rd_en = 1.
  - An instruction presented at T+2 is not decoded.
- HALT, then further instr_valid pulses → halted = 1 from T+1; no strobes follow; rst_n low clears halted without a clock edge.
- Opcode 0x3F (unassigned) → illegal_instr pulses 1 cycle, all strobes 0, a following ADDI decodes normally (rd1, a_wr, imm).
- Reset asserted during MULDIV_WAIT, counter = 2 → stall_out = 0 asynchronously; after release with boot_mode = 0, RUN is reached in 1 cycle.
